// File: rtl/fifo_rd_checker.sv
// Read-side drain-and-compare engine for asyn_fifo, entirely in the clk_rd domain.
// Optional first-error capture outputs are enabled by defining FIFO_RD_CHK_ERRCAP_EN.
module fifo_rd_checker #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 12
) (
  input  logic                  clk_rd,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] Dout,
  output logic                  en_rd,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [1:0]            dbg_state
`ifdef FIFO_RD_CHK_ERRCAP_EN
  ,
  output logic [CNT_WIDTH-1:0]  first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic [DATA_WIDTH-1:0] first_err_exp
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic                  rd_v_q, rd_v_d;
  logic                  pass_q, pass_d;
  logic                  accept;
  logic                  mismatch;

  assign accept   = (state_q == S_IDLE) && start;
  assign mismatch = rd_v_q && (Dout != exp_q);

  // Read handshake: a word is popped at the end of every cycle with en_rd high;
  // en_rd is only raised when empty is low, and the popped word is on Dout one
  // cycle later, where it is compared while rd_v_q is high.
  always_comb begin
    state_d = state_q;
    en_rd   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_READ;
      end
      S_READ: begin
        en_rd = !empty && ((len_q == '0) || (issued_q < len_q));
        if (len_q != '0) begin
          if ((issued_q + CNT_WIDTH'(en_rd)) == len_q) state_d = S_FLUSH;
        end else if (empty && !rd_v_q) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mode_d     = mode_q;
    len_d      = len_q;
    issued_d   = issued_q;
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    exp_d      = exp_q;
    pass_d     = pass_q;
    rd_v_d     = en_rd;
    if (accept) begin
      mode_d     = mode;
      len_d      = len;
      issued_d   = '0;
      word_cnt_d = '0;
      err_cnt_d  = '0;
      pass_d     = 1'b0;
      case (mode)
        2'b00:   exp_d = '0;
        2'b01:   exp_d = '1;
        default: exp_d = seed;
      endcase
    end else begin
      issued_d = issued_q + CNT_WIDTH'(en_rd);
      if (rd_v_q) begin
        word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
        if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        case (mode_q)
          2'b10:   exp_d = exp_q + DATA_WIDTH'(1);
          2'b11:   exp_d = exp_q - DATA_WIDTH'(1);
          default: exp_d = exp_q;
        endcase
      end
      // The last compare can land in the FLUSH cycle, so judge on the next count.
      if (state_q == S_FLUSH) pass_d = (err_cnt_d == '0);
    end
  end

  always_ff @(posedge clk_rd or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 2'b00;
      len_q      <= '0;
      issued_q   <= '0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      exp_q      <= '0;
      rd_v_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
      exp_q      <= exp_d;
      rd_v_q     <= rd_v_d;
      pass_q     <= pass_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign word_cnt  = word_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

`ifdef FIFO_RD_CHK_ERRCAP_EN
  logic [CNT_WIDTH-1:0]  fe_idx_q, fe_idx_d;
  logic [DATA_WIDTH-1:0] fe_data_q, fe_data_d;
  logic [DATA_WIDTH-1:0] fe_exp_q, fe_exp_d;

  // Only the first mismatch of a run is kept: err_cnt is still zero at that compare.
  always_comb begin
    fe_idx_d  = fe_idx_q;
    fe_data_d = fe_data_q;
    fe_exp_d  = fe_exp_q;
    if (accept) begin
      fe_idx_d  = '0;
      fe_data_d = '0;
      fe_exp_d  = '0;
    end else if (mismatch && (err_cnt_q == '0)) begin
      fe_idx_d  = word_cnt_q;
      fe_data_d = Dout;
      fe_exp_d  = exp_q;
    end
  end

  always_ff @(posedge clk_rd or negedge rst) begin
    if (!rst) begin
      fe_idx_q  <= '0;
      fe_data_q <= '0;
      fe_exp_q  <= '0;
    end else begin
      fe_idx_q  <= fe_idx_d;
      fe_data_q <= fe_data_d;
      fe_exp_q  <= fe_exp_d;
    end
  end

  assign first_err_idx  = fe_idx_q;
  assign first_err_data = fe_data_q;
  assign first_err_exp  = fe_exp_q;
`endif

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Bench for fifo_rd_checker: behavioural FIFO model, run-result scoreboard, directed runs.
module tb_fifo_rd_checker;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk_rd = 1'b0;
  logic          rst    = 1'b0;
  logic          start  = 1'b0;
  logic [1:0]    mode   = 2'b00;
  logic [DW-1:0] seed   = '0;
  logic [CW-1:0] len    = '0;
  logic          empty  = 1'b1;
  logic [DW-1:0] dout   = '0;
  logic          en_rd, busy, done, pass;
  logic [CW-1:0] word_cnt, err_cnt;
  logic [1:0]    dbg_state;
`ifdef FIFO_RD_CHK_ERRCAP_EN
  logic [CW-1:0] first_err_idx;
  logic [DW-1:0] first_err_data, first_err_exp;
`endif

  fifo_rd_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_rd    (clk_rd),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .len       (len),
    .empty     (empty),
    .Dout      (dout),
    .en_rd     (en_rd),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .word_cnt  (word_cnt),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
`ifdef FIFO_RD_CHK_ERRCAP_EN
    ,
    .first_err_idx  (first_err_idx),
    .first_err_data (first_err_data),
    .first_err_exp  (first_err_exp)
`endif
  );

  // clock / reset
  always #5 clk_rd = ~clk_rd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // FIFO model: writes staged in wr_q enter one per cycle; a read pops at the edge
  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] stim[$];

  always @(posedge clk_rd) begin
    if (!rst) begin
      fifo_q.delete();
      dout  <= '0;
      empty <= 1'b1;
    end else begin
      if (en_rd && (fifo_q.size() > 0)) dout <= fifo_q.pop_front();
      if (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
      empty <= (fifo_q.size() == 0);
    end
  end

  // scoreboard: {word_cnt, err_cnt, pass} expected per run, popped on done
  logic [2*CW:0] exp_q[$];
  logic [2*CW:0] sb_item;
  int rd_cnt = 0, last_rd = 0, busy_cyc = 0, last_busy = 0, done_total = 0, viol = 0;

  always @(negedge clk_rd) begin
    if (!rst) begin
      rd_cnt   = 0;
      busy_cyc = 0;
    end else begin
      if (en_rd) rd_cnt++;
      if (en_rd && empty) viol++;
      if (busy) busy_cyc++;
      if (done) begin
        done_total++;
        last_rd   = rd_cnt;
        last_busy = busy_cyc;
        rd_cnt    = 0;
        busy_cyc  = 0;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          sb_item = exp_q.pop_front();
          check("sb_word_cnt", 32'(word_cnt), 32'(sb_item[2*CW:CW+1]));
          check("sb_err_cnt", 32'(err_cnt), 32'(sb_item[CW:1]));
          check("sb_pass", 32'(pass), 32'(sb_item[0]));
        end
      end
    end
  end

  // reference model of one run over stim
  int            g_errs, g_fidx, base_done;
  logic [DW-1:0] g_fdata, g_fexp;

  task automatic model_run(input logic [1:0] m, input logic [DW-1:0] s, input logic [CW-1:0] l);
    logic [DW-1:0] e;
    int n;
    if (m == 2'b00) e = '0;
    else if (m == 2'b01) e = '1;
    else e = s;
    n = (l == '0) ? stim.size() : int'(l);
    g_errs = 0; g_fidx = 0; g_fdata = '0; g_fexp = '0;
    for (int i = 0; i < n; i++) begin
      if (stim[i] !== e) begin
        if (g_errs == 0) begin
          g_fidx = i; g_fdata = stim[i]; g_fexp = e;
        end
        g_errs++;
      end
      if (m == 2'b10) e = e + 8'd1;
      else if (m == 2'b11) e = e - 8'd1;
    end
    exp_q.push_back({CW'(n), CW'(g_errs), (g_errs == 0)});
  endtask

  // driver tasks
  task automatic fill();
    foreach (stim[i]) wr_q.push_back(stim[i]);
    for (int i = 0; i < 100 && wr_q.size() != 0; i++) @(negedge clk_rd);
    @(negedge clk_rd);
  endtask

  task automatic launch(input logic [1:0] m, input logic [DW-1:0] s, input logic [CW-1:0] l);
    model_run(m, s, l);
    base_done = done_total;
    @(negedge clk_rd);
    mode = m; seed = s; len = l; start = 1'b1;
    @(negedge clk_rd);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_rd);
      #1;
      if (done_total != base_done) seen = 1;
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  initial begin
    int d0;
    rst = 1'b0;
    repeat (3) @(negedge clk_rd);
    check("rst_en_rd", 32'(en_rd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk_rd);

    // 16 x 0x00, fixed length: back-to-back reads, busy N+2
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(8'h00);
    fill();
    launch(2'b00, 8'h00, 16'd16);
    wait_done(100);
    check("t_zero_rd_cnt", 32'(last_rd), 32'd16);
    check("t_zero_busy_cycles", 32'(last_busy), 32'd18);
    check("t_zero_done_pulses", 32'(done_total - base_done), 32'd1);

    // 16 x 0xFF, drain until empty
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(8'hFF);
    fill();
    launch(2'b01, 8'h00, 16'd0);
    wait_done(100);
    check("t_ones_rd_cnt", 32'(last_rd), 32'd16);
    check("t_ones_empty_after", 32'(empty), 32'd1);

    // increment across the data wrap
    stim = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    fill();
    launch(2'b10, 8'hFE, 16'd4);
    wait_done(100);

    // increment with one corrupted word
    stim = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h04};
    fill();
    launch(2'b10, 8'h00, 16'd5);
    wait_done(100);
    check("t_err_model_errs", 32'(err_cnt), 32'(g_errs));
`ifdef FIFO_RD_CHK_ERRCAP_EN
    check("t_err_first_idx", 32'(first_err_idx), 32'(g_fidx));
    check("t_err_first_data", 32'(first_err_data), 32'(g_fdata));
    check("t_err_first_exp", 32'(first_err_exp), 32'(g_fexp));
`endif

    // slow writer, decrement pattern, ignored second start
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(8'h10 - 8'(i));
    launch(2'b11, 8'h10, 16'd8);
    fork
      begin
        foreach (stim[i]) begin
          @(negedge clk_rd);
          wr_q.push_back(stim[i]);
          repeat (2) @(negedge clk_rd);
        end
      end
      begin
        repeat (4) @(negedge clk_rd);
        mode = 2'b00; len = 16'd2; start = 1'b1;
        @(negedge clk_rd);
        start = 1'b0;
        wait_done(200);
      end
    join
    repeat (4) @(negedge clk_rd);
    check("t_slow_rd_cnt", 32'(last_rd), 32'd8);
    check("t_slow_done_pulses", 32'(done_total - base_done), 32'd1);
    check("t_slow_busy_after", 32'(busy), 32'd0);
    check("en_rd_while_empty", 32'(viol), 32'd0);

    // reset during a run
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(8'h00);
    fill();
    launch(2'b00, 8'h00, 16'd16);
    for (int i = 0; i < 50 && rd_cnt < 5; i++) begin
      @(negedge clk_rd);
      #1;
    end
    check("t_rst_en_rd_before", 32'(en_rd), 32'd1);
    rst = 1'b0;
    #1;
    check("t_rst_en_rd", 32'(en_rd), 32'd0);
    check("t_rst_busy", 32'(busy), 32'd0);
    check("t_rst_done", 32'(done), 32'd0);
    check("t_rst_word_cnt", 32'(word_cnt), 32'd0);
    check("t_rst_err_cnt", 32'(err_cnt), 32'd0);
    check("t_rst_pass", 32'(pass), 32'd0);
    exp_q.delete();
    d0 = done_total;
    repeat (3) @(negedge clk_rd);
    rst = 1'b1;
    repeat (3) @(negedge clk_rd);
    check("t_rst_no_done", 32'(done_total), 32'(d0));

    // clean run after reset release
    stim = '{8'h05, 8'h06, 8'h07};
    fill();
    launch(2'b10, 8'h05, 16'd3);
    #1;
    check("t_post_busy", 32'(busy), 32'd1);
    check("t_post_word_cnt_start", 32'(word_cnt), 32'd0);
    wait_done(100);
    check("t_post_rd_cnt", 32'(last_rd), 32'd3);

    // empty FIFO, drain-until-empty mode
    stim.delete();
    launch(2'b10, 8'h00, 16'd0);
    wait_done(100);
    check("t_empty_rd_cnt", 32'(last_rd), 32'd0);
    check("t_empty_busy_cycles", 32'(last_busy), 32'd3);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
